// File: rtl/rv32i_mem_pkg.sv
// Shared encodings for the RV32I data-memory path: fun3 access codes and responder FSM states.
// Latency: none (declarations only).
// Backpressure: n/a.
package rv32i_mem_pkg;

  // fun3 access size / signedness codes (loads use all five, stores only B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for RV32I loads/stores: store enables + replicated data, load extraction + extension.
// Latency: purely combinational.
// Backpressure: none; the parent FSM decides when outputs are used.
// Ports:
//   is_store_i  request is a store (BU/HU are then illegal)
//   fun3_i      access size/sign code
//   addr_lo_i   byte address bits [1:0]
//   wdata_i     LSB-aligned store data
//   raw_i       full memory word at the addressed index
//   be_o        byte enables (all zero when misaligned)
//   wdata_o     store data replicated across lanes
//   misalign_o  misaligned or unsupported access
//   rdata_o     extended load data (zero when misaligned)
module dmem_align
  import rv32i_mem_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  fun3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = raw_i[{addr_lo_i, 3'b000} +: 8];
  assign half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

  always_comb begin
    misalign_o = 1'b1;
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = 32'd0;
    case (fun3_i)
      F3_B: begin
        misalign_o = 1'b0;
        be_o       = 4'b0001 << addr_lo_i;
        wdata_o    = {4{wdata_i[7:0]}};
        rdata_o    = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_H: begin
        misalign_o = addr_lo_i[0];
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{half_sel[15]}}, half_sel};
      end
      F3_W: begin
        misalign_o = |addr_lo_i;
        be_o       = 4'b1111;
        rdata_o    = raw_i;
      end
      // Unsigned variants exist only for loads; as a store they are unsupported.
      F3_BU: begin
        misalign_o = is_store_i;
        rdata_o    = {24'd0, byte_sel};
      end
      F3_HU: begin
        misalign_o = is_store_i | addr_lo_i[0];
        rdata_o    = {16'd0, half_sel};
      end
      default: begin
        misalign_o = 1'b1;
      end
    endcase
    // A rejected access must neither write nor return data.
    if (misalign_o) begin
      be_o    = 4'b0000;
      rdata_o = 32'd0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, stalls the pipe LATENCY cycles, then pulses dm_valid_o.
// Latency: accept-to-dm_valid_o is LATENCY cycles; load data/err are registered into the response cycle.
// Backpressure: busy_o is high from the accept cycle through the response cycle; requests are level-held.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   load_i, store_i   request levels (store wins when both are high)
//   fun3_i            access size/sign
//   addr_i            byte address; word index wraps on DEPTH_WORDS
//   wdata_i           LSB-aligned store data
//   busy_o            stall request
//   dm_valid_o        one-cycle completion pulse
//   dm_err_o          misaligned/unsupported access, qualified by dm_valid_o
//   rdata_o           extended load data, zero outside dm_valid_o
module dmem_responder
  import rv32i_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int FUNCTION3   = 3,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  store_i,
  input  logic [FUNCTION3-1:0]  fun3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  dm_valid_o,
  output logic                  dm_err_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Counter only has to hold LATENCY-2.
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

  dmem_state_t state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  skip_q;
  logic                  is_store_q;
  logic [FUNCTION3-1:0]  fun3_q;
  logic [1:0]            addr_lo_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  logic                  accept;
  logic                  to_resp;
  logic                  req_store;
  logic [FUNCTION3-1:0]  req_fun3;
  logic [1:0]            req_addr_lo;
  logic [IDX_W-1:0]      req_idx;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic                  misalign;
  logic [DATA_WIDTH-1:0] ld_data;

  // Address bits above the word index are deliberately ignored (wrap-around).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[ADDR_WIDTH-1:IDX_W+2];

  // The cycle right after a response still sees the old request level; skip_q masks it.
  assign accept = (state_q == IDLE) && !skip_q && (load_i || store_i);

  // In IDLE the live inputs drive the aligner so a LATENCY==1 read can use them directly;
  // otherwise the latched request does.
  always_comb begin
    if (state_q == IDLE) begin
      req_store   = store_i;
      req_fun3    = fun3_i;
      req_addr_lo = addr_i[1:0];
      req_idx     = addr_i[2 +: IDX_W];
      req_wdata   = wdata_i;
    end else begin
      req_store   = is_store_q;
      req_fun3    = fun3_q;
      req_addr_lo = addr_lo_q;
      req_idx     = idx_q;
      req_wdata   = wdata_q;
    end
  end

  dmem_align u_align (
    .is_store_i (req_store),
    .fun3_i     (req_fun3),
    .addr_lo_i  (req_addr_lo),
    .wdata_i    (req_wdata),
    .raw_i      (mem_q[req_idx]),
    .be_o       (be),
    .wdata_o    (st_wdata),
    .misalign_o (misalign),
    .rdata_o    (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign to_resp = (state_d == RESP) && (state_q != RESP);

  // Response fields are captured on entry to RESP so they appear alongside dm_valid_o.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (to_resp) begin
      err_d = misalign;
      if (!req_store) begin
        rdata_d = ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      skip_q     <= 1'b0;
      is_store_q <= 1'b0;
      fun3_q     <= '0;
      addr_lo_q  <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= (state_q == RESP);
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        is_store_q <= store_i;
        fun3_q     <= fun3_i;
        addr_lo_q  <= addr_i[1:0];
        idx_q      <= addr_i[2 +: IDX_W];
        wdata_q    <= wdata_i;
      end
    end
  end

  // Stores commit on the edge that ends RESP; a reset on that edge discards the write.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == RESP) && is_store_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[idx_q][8*b +: 8] <= st_wdata[8*b +: 8];
        end
      end
    end
  end

  assign busy_o     = (state_q != IDLE) || accept;
  assign dm_valid_o = (state_q == RESP);
  assign dm_err_o   = err_q;
  assign rdata_o    = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued at request time and matched on dm_valid_o.
// Latency: checks accept-to-valid distance equals LAT and busy_o over the whole transaction.
// Backpressure: requests are held until one cycle after dm_valid_o, as the decoder does.
module tb_dmem_responder;
  import rv32i_mem_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_i, store_i;
  logic [2:0]  fun3_i;
  logic [31:0] addr_i, wdata_i;
  logic        busy_o, dm_valid_o, dm_err_o;
  logic [31:0] rdata_o;

  int checks   = 0;
  int failures = 0;

  logic [32:0] sb_q[$];
  logic [32:0] exp_e;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .FUNCTION3  (3),
    .DEPTH_WORDS(1024),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_i),
    .store_i   (store_i),
    .fun3_i    (fun3_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .busy_o    (busy_o),
    .dm_valid_o(dm_valid_o),
    .dm_err_o  (dm_err_o),
    .rdata_o   (rdata_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && dm_valid_o) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_valid", {31'd0, dm_valid_o}, 32'd0);
      end else begin
        exp_e = sb_q.pop_front();
        check_val("resp_err", {31'd0, dm_err_o}, {31'd0, exp_e[32]});
        check_val("resp_rdata", rdata_o, exp_e[31:0]);
      end
    end
  end

  task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
    int n;
    @(posedge clk);
    #1;
    load_i  = ld;
    store_i = st;
    fun3_i  = f3;
    addr_i  = a;
    wdata_i = wd;
    sb_q.push_back({exp_err, exp_rd});
    n = 0;
    forever begin
      @(negedge clk);
      check_val({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
      if (dm_valid_o) break;
      n++;
      if (n > 20) begin
        check_val({tag, "_timeout"}, n, LAT);
        break;
      end
    end
    check_val({tag, "_lat"}, n, LAT);
    // Request is still asserted in the cycle after the response; it must be ignored.
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val({tag, "_skip_busy"}, {31'd0, busy_o}, 32'd0);
    check_val({tag, "_skip_valid"}, {31'd0, dm_valid_o}, 32'd0);
    check_val({tag, "_skip_rdata"}, rdata_o, 32'd0);
    @(posedge clk);
    #1;
    load_i  = 1'b0;
    store_i = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    load_i  = 1'b0;
    store_i = 1'b0;
    fun3_i  = 3'b000;
    addr_i  = 32'd0;
    wdata_i = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", {31'd0, busy_o}, 32'd0);
    check_val("rst_valid", {31'd0, dm_valid_o}, 32'd0);
    check_val("rst_err", {31'd0, dm_err_o}, 32'd0);
    check_val("rst_rdata", rdata_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Word store then read back
    run_op("sw_10",  1'b0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    run_op("lw_10",  1'b1, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'hDEADBEEF);
    // Sub-word loads with sign/zero extension
    run_op("lb_13",  1'b1, 1'b0, F3_B,  32'h13, 32'h0,        1'b0, 32'hFFFFFFDE);
    run_op("lbu_13", 1'b1, 1'b0, F3_BU, 32'h13, 32'h0,        1'b0, 32'h000000DE);
    run_op("lh_12",  1'b1, 1'b0, F3_H,  32'h12, 32'h0,        1'b0, 32'hFFFFDEAD);
    run_op("lhu_10", 1'b1, 1'b0, F3_HU, 32'h10, 32'h0,        1'b0, 32'h0000BEEF);
    // Byte store touches only lane 1
    run_op("sb_11",  1'b0, 1'b1, F3_B,  32'h11, 32'h00000055, 1'b0, 32'h0);
    run_op("lw_10b", 1'b1, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'hDEAD55EF);
    // Misaligned and unsupported accesses
    run_op("lw_12",  1'b1, 1'b0, F3_W,  32'h12, 32'h0,        1'b1, 32'h0);
    run_op("sh_11",  1'b0, 1'b1, F3_H,  32'h11, 32'h0000AAAA, 1'b1, 32'h0);
    run_op("l_f011", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0,       1'b1, 32'h0);
    run_op("lw_10c", 1'b1, 1'b0, F3_W,  32'h10, 32'h0,        1'b0, 32'hDEAD55EF);
    // Upper address bits wrap onto the same word
    run_op("lw_wrap", 1'b1, 1'b0, F3_W, 32'h1010, 32'h0,      1'b0, 32'hDEAD55EF);
    // Load and store together: the store is performed, no load data
    run_op("ls_30",  1'b1, 1'b1, F3_W,  32'h30, 32'h11223344, 1'b0, 32'h0);
    run_op("lw_30",  1'b1, 1'b0, F3_W,  32'h30, 32'h0,        1'b0, 32'h11223344);
    // Reset during WAIT discards the pending store
    run_op("sw_20",  1'b0, 1'b1, F3_W,  32'h20, 32'hCAFEF00D, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    store_i = 1'b1;
    fun3_i  = F3_W;
    addr_i  = 32'h20;
    wdata_i = 32'h12345678;
    @(negedge clk);
    check_val("rmid_accept_busy", {31'd0, busy_o}, 32'd1);
    @(posedge clk);
    #1;
    store_i = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check_val("rmid_wait_busy", {31'd0, busy_o}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("rmid_busy", {31'd0, busy_o}, 32'd0);
    check_val("rmid_valid", {31'd0, dm_valid_o}, 32'd0);
    check_val("rmid_err", {31'd0, dm_err_o}, 32'd0);
    check_val("rmid_rdata", rdata_o, 32'd0);
    repeat (3) @(posedge clk);
    run_op("lw_20",  1'b1, 1'b0, F3_W,  32'h20, 32'h0,        1'b0, 32'hCAFEF00D);

    repeat (5) @(posedge clk);
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
